// File: rtl/ncc_pkg.sv
// Shared constants, score type and FSM state encoding for the NCC peak tracker.
package ncc_pkg;

   localparam int unsigned NUM_ROWS = 16;
   localparam int unsigned ACC_W    = 8;
   localparam int unsigned SCORE_W  = ACC_W + 4;
   localparam int unsigned PART_W   = ACC_W + 2;

   typedef logic signed [SCORE_W-1:0] score_t;
   typedef logic signed [PART_W-1:0]  part_t;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } peak_state_e;

   localparam score_t ScoreMin = {1'b1, {(SCORE_W-1){1'b0}}};

endpackage

// File: rtl/ncc_row_adder_tree.sv
// Two-stage pipelined signed sum of the 16 row accumulators, carrying a valid bit and
// a position tag alongside the data. flush_i kills both stages' valid bits.
module ncc_row_adder_tree
   import ncc_pkg::*;
#(
   parameter int unsigned TagW = 12
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      flush_i,
   input  logic                      valid_i,
   input  logic [NUM_ROWS*ACC_W-1:0] data_i,
   input  logic [TagW-1:0]           tag_i,
   output logic                      stage1_valid_o,
   output logic                      valid_o,
   output score_t                    score_o,
   output logic [TagW-1:0]           tag_o
);

   part_t [3:0]     s1_sum_d;
   part_t [3:0]     s1_sum_q;
   logic            s1_valid_q;
   logic [TagW-1:0] s1_tag_q;
   score_t          s2_sum_d;
   score_t          s2_sum_q;
   logic            s2_valid_q;
   logic [TagW-1:0] s2_tag_q;

   always_comb begin
      for (int g = 0; g < 4; g++) begin
         s1_sum_d[g] = '0;
         for (int k = 0; k < 4; k++) begin
            s1_sum_d[g] = s1_sum_d[g] + part_t'($signed(data_i[(4*g+k)*ACC_W +: ACC_W]));
         end
      end
   end

   always_comb begin
      s2_sum_d = score_t'($signed(s1_sum_q[0])) + score_t'($signed(s1_sum_q[1]))
               + score_t'($signed(s1_sum_q[2])) + score_t'($signed(s1_sum_q[3]));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid_q <= 1'b0;
         s1_sum_q   <= '0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_sum_q   <= '0;
         s2_tag_q   <= '0;
      end else begin
         s1_valid_q <= valid_i & ~flush_i;
         s2_valid_q <= s1_valid_q & ~flush_i;
         // Data registers only move with real samples to avoid needless toggling.
         if (valid_i) begin
            s1_sum_q <= s1_sum_d;
            s1_tag_q <= tag_i;
         end
         if (s1_valid_q) begin
            s2_sum_q <= s2_sum_d;
            s2_tag_q <= s1_tag_q;
         end
      end
   end

   assign stage1_valid_o = s1_valid_q;
   assign valid_o        = s2_valid_q;
   assign score_o        = s2_sum_q;
   assign tag_o          = s2_tag_q;

endmodule

// File: rtl/ncc_peak_tracker.sv
// Sums NCC row accumulators per raster position and reports the maximum score and its location.
// Optional NCC_PEAK_THRESH_EN adds a min_score input and a peak_found flag.
module ncc_peak_tracker
   import ncc_pkg::*;
#(
   parameter int unsigned SEARCH_W = 64,
   parameter int unsigned SEARCH_H = 64,
   localparam int unsigned XW = $clog2(SEARCH_W),
   localparam int unsigned YW = $clog2(SEARCH_H)
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      start_i,
   input  logic                      acc_valid_i,
   input  logic [NUM_ROWS*ACC_W-1:0] acc_in_i,
`ifdef NCC_PEAK_THRESH_EN
   input  score_t                    min_score_i,
   output logic                      peak_found_o,
`endif
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      peak_valid_o,
   output score_t                    peak_score_o,
   output logic [XW-1:0]             peak_x_o,
   output logic [YW-1:0]             peak_y_o
);

   peak_state_e     state_q, state_d;
   logic [XW-1:0]   x_q, x_d;
   logic [YW-1:0]   y_q, y_d;
   logic            accept;
   logic            last_pos;
   logic            s1_valid;
   logic            tree_valid;
   score_t          tree_score;
   logic [XW+YW-1:0] tree_tag;

   score_t          max_q;
   logic [XW-1:0]   max_x_q;
   logic [YW-1:0]   max_y_q;

   logic            done_q;
   logic            peak_valid_q;
   score_t          peak_score_q;
   logic [XW-1:0]   peak_x_q;
   logic [YW-1:0]   peak_y_q;

   // A start in the same cycle flushes the pipe, so its acc_valid must not enter.
   assign accept   = (state_q == StRun) & acc_valid_i & ~start_i;
   assign last_pos = (x_q == XW'(SEARCH_W - 1)) && (y_q == YW'(SEARCH_H - 1));

   ncc_row_adder_tree #(
      .TagW (XW + YW)
   ) u_tree (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .flush_i        (start_i),
      .valid_i        (accept),
      .data_i         (acc_in_i),
      .tag_i          ({y_q, x_q}),
      .stage1_valid_o (s1_valid),
      .valid_o        (tree_valid),
      .score_o        (tree_score),
      .tag_o          (tree_tag)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_i) state_d = StRun;
         StRun: begin
            if (start_i) begin
               state_d = StRun;
            end else if (accept && last_pos) begin
               state_d = StDrain;
            end
         end
         // Stage 2 is consumed on this edge, so only stage 1 can still hold data.
         StDrain: begin
            if (start_i) begin
               state_d = StRun;
            end else if (!s1_valid) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = start_i ? StRun : StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy_o = (state_q != StIdle);
   end

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (start_i) begin
         x_d = '0;
         y_d = '0;
      end else if (accept) begin
         if (x_q == XW'(SEARCH_W - 1)) begin
            x_d = '0;
            y_d = y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   // Strictly-greater update keeps the earliest raster position on ties.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         max_q   <= ScoreMin;
         max_x_q <= '0;
         max_y_q <= '0;
      end else if (start_i) begin
         max_q   <= ScoreMin;
         max_x_q <= '0;
         max_y_q <= '0;
      end else if (tree_valid && (tree_score > max_q)) begin
         max_q   <= tree_score;
         max_x_q <= tree_tag[XW-1:0];
         max_y_q <= tree_tag[XW+YW-1:XW];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         done_q       <= 1'b0;
         peak_valid_q <= 1'b0;
         peak_score_q <= '0;
         peak_x_q     <= '0;
         peak_y_q     <= '0;
      end else begin
         done_q <= 1'b0;
         if (start_i) begin
            peak_valid_q <= 1'b0;
         end else if (state_q == StDone) begin
            done_q       <= 1'b1;
            peak_valid_q <= 1'b1;
            peak_score_q <= max_q;
            peak_x_q     <= max_x_q;
            peak_y_q     <= max_y_q;
         end
      end
   end

`ifdef NCC_PEAK_THRESH_EN
   score_t min_q;
   logic   peak_found_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         min_q        <= '0;
         peak_found_q <= 1'b0;
      end else if (start_i) begin
         min_q        <= min_score_i;
         peak_found_q <= 1'b0;
      end else if (state_q == StDone) begin
         peak_found_q <= (max_q >= min_q);
      end
   end

   assign peak_found_o = peak_found_q;
`endif

   assign done_o       = done_q;
   assign peak_valid_o = peak_valid_q;
   assign peak_score_o = peak_score_q;
   assign peak_x_o     = peak_x_q;
   assign peak_y_o     = peak_y_q;

endmodule

// File: tb/tb_ncc_peak_tracker.sv
// Self-checking bench for ncc_peak_tracker on a 4x4 search region with a plain-arithmetic
// reference model of the raster peak search.
module tb_ncc_peak_tracker;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic               acc_valid;
   logic [127:0]       acc_in;
   logic               busy;
   logic               done;
   logic               peak_valid;
   logic signed [11:0] peak_score;
   logic [1:0]         peak_x;
   logic [1:0]         peak_y;
`ifdef NCC_PEAK_THRESH_EN
   logic signed [11:0] min_score;
   logic               peak_found;
`endif

   int total;
   int bad;
   int done_cnt;
   int rows_q [16][16];

   ncc_peak_tracker #(
      .SEARCH_W (4),
      .SEARCH_H (4)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .acc_valid_i  (acc_valid),
      .acc_in_i     (acc_in),
`ifdef NCC_PEAK_THRESH_EN
      .min_score_i  (min_score),
      .peak_found_o (peak_found),
`endif
      .busy_o       (busy),
      .done_o       (done),
      .peak_valid_o (peak_valid),
      .peak_score_o (peak_score),
      .peak_x_o     (peak_x),
      .peak_y_o     (peak_y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   function automatic logic [127:0] pack_pos(int p);
      logic [127:0] v;
      int t;
      v = '0;
      for (int r = 0; r < 16; r++) begin
         t = rows_q[p][r];
         v[r*8 +: 8] = t[7:0];
      end
      return v;
   endfunction

   task automatic fill_const(input int v);
      for (int p = 0; p < 16; p++)
         for (int r = 0; r < 16; r++) rows_q[p][r] = v;
   endtask

   task automatic set_pos(input int p, input int v);
      for (int r = 0; r < 16; r++) rows_q[p][r] = v;
   endtask

   // Reference: score = plain sum of rows; first strictly larger score in raster order wins.
   task automatic model_peak(output logic signed [11:0] sc, output logic [1:0] x,
                             output logic [1:0] y);
      int best, bx, by, s;
      best = -2048; bx = 0; by = 0;
      for (int p = 0; p < 16; p++) begin
         s = 0;
         for (int r = 0; r < 16; r++) s += rows_q[p][r];
         if (s > best) begin
            best = s; bx = p % 4; by = p / 4;
         end
      end
      sc = 12'(best);
      x  = 2'(bx);
      y  = 2'(by);
   endtask

   // Drives a full search and reports what was observed; callers do their own checks.
   task automatic run_search(input bit gaps, output int lat, output logic busy_start,
                             output logic busy_done, output logic done_after,
                             output logic pv_after, output logic signed [11:0] sc,
                             output logic [1:0] x, output logic [1:0] y, output logic found);
      @(negedge clk);
      start = 1'b1; acc_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      busy_start = busy;
      for (int p = 0; p < 16; p++) begin
         while (gaps && $urandom_range(0, 3) == 0) begin
            acc_valid = 1'b0;
            acc_in = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
         end
         acc_valid = 1'b1;
         acc_in = pack_pos(p);
         @(negedge clk);
      end
      acc_valid = 1'b0;
      lat = -1;
      for (int c = 0; c <= 20; c++) begin
         if (done === 1'b1) begin
            lat = c;
            break;
         end
         @(negedge clk);
      end
      busy_done = busy;
      sc = peak_score; x = peak_x; y = peak_y;
`ifdef NCC_PEAK_THRESH_EN
      found = peak_found;
`else
      found = 1'b0;
`endif
      @(negedge clk);
      done_after = done;
      pv_after = peak_valid;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; acc_valid = 1'b0; acc_in = '0;
`ifdef NCC_PEAK_THRESH_EN
      min_score = '0;
`endif
      repeat (3) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++;
      if (peak_valid !== 1'b0) begin bad++; $display("FAIL reset_pv got=%b want=0", peak_valid); end
      total++;
      if ({peak_score, peak_x, peak_y} !== 16'h0) begin
         bad++; $display("FAIL reset_peak got=%0d,%0d,%0d want=0,0,0", peak_score, peak_x, peak_y);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_peak();
      int lat; logic bs, bd, da, pv, f; logic signed [11:0] sc, esc; logic [1:0] x, y, ex, ey;
      fill_const(0);
      set_pos(6, 1);
      model_peak(esc, ex, ey);
      run_search(1'b0, lat, bs, bd, da, pv, sc, x, y, f);
      total++; if (bs !== 1'b1) begin bad++; $display("FAIL single_busy_rise got=%b want=1", bs); end
      total++; if (lat != 3) begin bad++; $display("FAIL single_latency got=%0d want=3", lat); end
      total++; if (bd !== 1'b0) begin bad++; $display("FAIL single_busy_fall got=%b want=0", bd); end
      total++; if (da !== 1'b0) begin bad++; $display("FAIL single_done_pulse got=%b want=0", da); end
      total++; if (pv !== 1'b1) begin bad++; $display("FAIL single_pv_hold got=%b want=1", pv); end
      total++;
      if (sc !== esc || x !== ex || y !== ey) begin
         bad++; $display("FAIL single_peak got=%0d,(%0d,%0d) want=%0d,(%0d,%0d)", sc, x, y, esc, ex, ey);
      end
   endtask

   task automatic test_all_negative();
      int lat; logic bs, bd, da, pv, f; logic signed [11:0] sc, esc; logic [1:0] x, y, ex, ey;
      fill_const(-128);
      set_pos(15, -127);
      model_peak(esc, ex, ey);
      run_search(1'b0, lat, bs, bd, da, pv, sc, x, y, f);
      total++;
      if (sc !== esc || x !== ex || y !== ey) begin
         bad++; $display("FAIL neg_peak got=%0d,(%0d,%0d) want=%0d,(%0d,%0d)", sc, x, y, esc, ex, ey);
      end
      fill_const(-128);
      model_peak(esc, ex, ey);
      run_search(1'b0, lat, bs, bd, da, pv, sc, x, y, f);
      total++;
      if (sc !== esc || x !== ex || y !== ey) begin
         bad++; $display("FAIL neg_floor got=%0d,(%0d,%0d) want=%0d,(%0d,%0d)", sc, x, y, esc, ex, ey);
      end
   endtask

   task automatic test_tie();
      int lat; logic bs, bd, da, pv, f; logic signed [11:0] sc, esc; logic [1:0] x, y, ex, ey;
      fill_const(0);
      rows_q[5][0] = 40;
      rows_q[11][3] = 40;
      model_peak(esc, ex, ey);
      run_search(1'b0, lat, bs, bd, da, pv, sc, x, y, f);
      total++;
      if (sc !== esc || x !== ex || y !== ey) begin
         bad++; $display("FAIL tie_peak got=%0d,(%0d,%0d) want=%0d,(%0d,%0d)", sc, x, y, esc, ex, ey);
      end
   endtask

   task automatic test_restart();
      int lat, d0; logic bs, bd, da, pv, f; logic signed [11:0] sc, esc; logic [1:0] x, y, ex, ey;
      logic [127:0] v;
      d0 = done_cnt;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         v = '0;
         if (i == 3) for (int r = 0; r < 4; r++) v[r*8 +: 8] = 8'd25;
         acc_valid = 1'b1; acc_in = v;
         @(negedge clk);
      end
      acc_valid = 1'b0;
      fill_const(0);
      rows_q[9][0] = 10;
      rows_q[9][7] = 10;
      rows_q[2][1] = -5;
      model_peak(esc, ex, ey);
      run_search(1'b0, lat, bs, bd, da, pv, sc, x, y, f);
      total++;
      if (done_cnt - d0 != 1) begin
         bad++; $display("FAIL restart_done_count got=%0d want=1", done_cnt - d0);
      end
      total++;
      if (sc !== esc || x !== ex || y !== ey) begin
         bad++; $display("FAIL restart_peak got=%0d,(%0d,%0d) want=%0d,(%0d,%0d)", sc, x, y, esc, ex, ey);
      end
   endtask

   task automatic test_mid_reset();
      int d0; logic seen_busy;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         acc_valid = 1'b1; acc_in = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
      total++;
      if (peak_valid !== 1'b0) begin bad++; $display("FAIL midrst_pv got=%b want=0", peak_valid); end
      total++;
      if ({peak_score, peak_x, peak_y} !== 16'h0) begin
         bad++; $display("FAIL midrst_peak got=%0d,%0d,%0d want=0,0,0", peak_score, peak_x, peak_y);
      end
      acc_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      d0 = done_cnt;
      seen_busy = 1'b0;
      for (int i = 0; i < 24; i++) begin
         acc_valid = 1'b1; acc_in = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         if (busy !== 1'b0) seen_busy = 1'b1;
      end
      acc_valid = 1'b0;
      repeat (4) @(negedge clk);
      total++;
      if (seen_busy !== 1'b0 || done_cnt != d0) begin
         bad++; $display("FAIL idle_ignores_valid got=busy%b,dones%0d want=busy0,dones0", seen_busy,
                         done_cnt - d0);
      end
   endtask

   task automatic test_random();
      int lat, span; logic bs, bd, da, pv, f; logic signed [11:0] sc, esc; logic [1:0] x, y, ex, ey;
      for (int it = 0; it < 6; it++) begin
         span = (it % 2 == 0) ? 128 : 2;
         for (int p = 0; p < 16; p++)
            for (int r = 0; r < 16; r++)
               rows_q[p][r] = int'($urandom_range(0, 2 * span - 1)) - span;
         if (span == 128) for (int r = 0; r < 16; r++) if (rows_q[0][r] > 127) rows_q[0][r] = 127;
         model_peak(esc, ex, ey);
         run_search(1'b1, lat, bs, bd, da, pv, sc, x, y, f);
         total++;
         if (lat != 3 || sc !== esc || x !== ex || y !== ey) begin
            bad++;
            $display("FAIL random_%0d got=lat%0d,%0d,(%0d,%0d) want=lat3,%0d,(%0d,%0d)", it, lat, sc,
                     x, y, esc, ex, ey);
         end
      end
   endtask

`ifdef NCC_PEAK_THRESH_EN
   task automatic test_threshold();
      int lat; logic bs, bd, da, pv, f; logic signed [11:0] sc; logic [1:0] x, y;
      min_score = 12'sd50;
      fill_const(0);
      rows_q[7][0] = 49;
      run_search(1'b0, lat, bs, bd, da, pv, sc, x, y, f);
      total++;
      if (f !== 1'b0 || sc !== 12'sd49) begin
         bad++; $display("FAIL thresh_below got=found%b,%0d want=found0,49", f, sc);
      end
      rows_q[7][0] = 50;
      run_search(1'b0, lat, bs, bd, da, pv, sc, x, y, f);
      total++;
      if (f !== 1'b1 || sc !== 12'sd50) begin
         bad++; $display("FAIL thresh_equal got=found%b,%0d want=found1,50", f, sc);
      end
   endtask
`endif

   initial begin
      total = 0;
      bad = 0;
      done_cnt = 0;
      test_reset();
      test_single_peak();
      test_all_negative();
      test_tie();
      test_restart();
      test_mid_reset();
      test_random();
`ifdef NCC_PEAK_THRESH_EN
      test_threshold();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
